vnp4_ingress_wrr_switch: RTL

//  Parametrised N:1 AXI4-Stream ingress switch feeding the VNP4 pipeline from QDMA PF and CMAC ports.

---
 rtl/vnp4_ingress_wrr_switch_pkg.sv | 17 +
 rtl/vnp4_ingress_wrr_switch_if.sv | 31 +++
 rtl/vnp4_ingress_wrr_switch_skid.sv | 42 ++++
 rtl/vnp4_ingress_wrr_switch.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vnp4_ingress_wrr_switch_pkg.sv
// Shared types, field widths and ingress-ID helpers for the VNP4 ingress switch.
package vnp4_ingress_pkg;

  typedef enum logic {IDLE, STREAM} state_t;

  localparam int PORT_ID_W = 4;
  localparam int SIZE_W    = 16;

  function automatic logic [PORT_ID_W-1:0] pf_port_id(input int q, input int f);
    return PORT_ID_W'(q * 4 + f);
  endfunction

  function automatic logic [PORT_ID_W-1:0] cmac_port_id(input int c);
    return PORT_ID_W'(8 + c);
  endfunction

endpackage

// File: rtl/vnp4_ingress_wrr_switch_if.sv
// Stream bundles for the switch: N-wide ingress side and single egress side with sideband.
interface vnp4_axis_in_if #(parameter int NUM_PORTS = 4, parameter int DATA_W = 512);
  import vnp4_ingress_pkg::*;
  logic [NUM_PORTS-1:0]          tvalid;
  logic [NUM_PORTS*DATA_W-1:0]   tdata;
  logic [NUM_PORTS*DATA_W/8-1:0] tkeep;
  logic [NUM_PORTS-1:0]          tlast;
  logic [NUM_PORTS*SIZE_W-1:0]   tuser_size;
  logic [NUM_PORTS-1:0]          tready;

  modport master (output tvalid, tdata, tkeep, tlast, tuser_size, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser_size, output tready);
endinterface

interface vnp4_axis_out_if #(parameter int DATA_W = 512);
  import vnp4_ingress_pkg::*;
  logic                 tvalid;
  logic [DATA_W-1:0]    tdata;
  logic [DATA_W/8-1:0]  tkeep;
  logic                 tlast;
  logic [SIZE_W-1:0]    tuser_size;
  logic [PORT_ID_W-1:0] tuser_ingress;
  logic [PORT_ID_W-1:0] tuser_egress;
  logic                 tuser_valid;
  logic                 tready;

  modport master (output tvalid, tdata, tkeep, tlast, tuser_size, tuser_ingress,
                  tuser_egress, tuser_valid, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser_size, tuser_ingress,
                  tuser_egress, tuser_valid, output tready);
endinterface

// File: rtl/vnp4_ingress_wrr_switch_skid.sv
// Two-entry registered stage: 1 cycle latency, 1 beat/cycle; in_rdy drops only when both entries hold data.
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  logic         skid_vld;
  logic [W-1:0] skid_dat;

  assign in_rdy = ~skid_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (!out_vld || out_rdy) begin
      if (skid_vld) begin
        out_dat  <= skid_dat;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= in_vld;
        if (in_vld) out_dat <= in_dat;
      end
    end else if (in_vld && !skid_vld) begin
      // output is stalled: park the beat so the head stays stable
      skid_dat <= in_dat;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/vnp4_ingress_wrr_switch.sv
// N:1 packet-atomic weighted round-robin ingress switch stamping ingress ID and size into sideband.
// Latency 1 cycle accept->out; one idle cycle per arbitration change; source tready follows the skid stage.
module vnp4_ingress_wrr_switch import vnp4_ingress_pkg::*; #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 512,
  parameter int WEIGHT_W  = 4,
  parameter logic [NUM_PORTS*PORT_ID_W-1:0] PORT_ID_TABLE =
    {cmac_port_id(1), cmac_port_id(0), pf_port_id(0, 1), pf_port_id(0, 0)}
) (
  input  logic                          aclk,
  input  logic                          areset,
  vnp4_axis_in_if.slave                 s_axis,
  vnp4_axis_out_if.master               m_axis,
  input  logic [NUM_PORTS-1:0]          cfg_port_enable,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] cfg_weight
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int KEEP_W = DATA_W / 8;
  localparam int PAY_W  = DATA_W + KEEP_W + 1 + SIZE_W + PORT_ID_W;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    grant, grant_nxt, rr_ptr, rr_nxt, pick, scan;
  logic [WEIGHT_W-1:0] credit, credit_nxt, pick_w;
  logic                any_elig;
  logic [NUM_PORTS-1:0] eligible;

  logic                 sel_vld, sel_last, sel_en;
  logic [DATA_W-1:0]    sel_dat;
  logic [KEEP_W-1:0]    sel_keep;
  logic [SIZE_W-1:0]    sel_size;
  logic [PORT_ID_W-1:0] sel_id;
  logic                 skid_in_vld, skid_rdy, beat_acc;
  logic [PAY_W-1:0]     skid_out;

  assign eligible = s_axis.tvalid & cfg_port_enable;

  // first eligible port at or after rr_ptr; scanning backwards leaves the nearest one
  always_comb begin
    pick     = '0;
    scan     = '0;
    any_elig = 1'b0;
    pick_w   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      scan = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (eligible[scan]) begin
        pick     = scan;
        any_elig = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++)
      if (pick == IDX_W'(i)) pick_w = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_en   = 1'b0;
    sel_dat  = '0;
    sel_keep = '0;
    sel_size = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_vld  = s_axis.tvalid[i];
        sel_last = s_axis.tlast[i];
        sel_en   = cfg_port_enable[i];
        sel_dat  = s_axis.tdata[i*DATA_W +: DATA_W];
        sel_keep = s_axis.tkeep[i*KEEP_W +: KEEP_W];
        sel_size = s_axis.tuser_size[i*SIZE_W +: SIZE_W];
        sel_id   = PORT_ID_TABLE[i*PORT_ID_W +: PORT_ID_W];
      end
    end
  end

  always_comb begin
    s_axis.tready = '0;
    if (state == STREAM)
      for (int i = 0; i < NUM_PORTS; i++)
        if (grant == IDX_W'(i)) s_axis.tready[i] = skid_rdy;
  end

  assign skid_in_vld = (state == STREAM) && sel_vld;
  assign beat_acc    = skid_in_vld && skid_rdy;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
      credit <= credit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_nxt     = rr_ptr;
    credit_nxt = credit;
    case (state)
      IDLE: begin
        if (any_elig) begin
          grant_nxt  = pick;
          credit_nxt = (pick_w == '0) ? WEIGHT_W'(1) : pick_w;
          state_nxt  = STREAM;
        end
      end
      STREAM: begin
        // decisions happen only at packet boundaries, so a grant never moves mid-packet
        if (beat_acc && sel_last) begin
          credit_nxt = credit - 1'b1;
          if (!(credit > WEIGHT_W'(1) && sel_en)) begin
            rr_nxt    = (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  axis_skid_reg #(.W(PAY_W)) u_skid (
    .clk     (aclk),
    .rst     (areset),
    .in_vld  (skid_in_vld),
    .in_dat  ({sel_dat, sel_keep, sel_last, sel_size, sel_id}),
    .in_rdy  (skid_rdy),
    .out_vld (m_axis.tvalid),
    .out_dat (skid_out),
    .out_rdy (m_axis.tready)
  );

  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser_size, m_axis.tuser_ingress} = skid_out;
  assign m_axis.tuser_valid  = m_axis.tvalid;
  assign m_axis.tuser_egress = '0;

endmodule
